wiphy: RTL and testbench

WIPHY -- requirements
Module: wiphy

---
 rtl/wiphy_pkg.sv | 42 ++++
 rtl/wiphy_fifo.sv | 39 +++
 rtl/wiphy.sv | 170 +++++++++++++++++
 tb/tb_wiphy.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/wiphy_pkg.sv
// Shared register map, bit positions, response codes and small helpers for the wiphy block.
package wiphy_pkg;
    localparam logic [15:0] OFF_ID       = 16'h0000;
    localparam logic [15:0] OFF_CONTROL  = 16'h0004;
    localparam logic [15:0] OFF_STATUS   = 16'h0008;
    localparam logic [15:0] OFF_IRQ_EN   = 16'h000C;
    localparam logic [15:0] OFF_TX_COUNT = 16'h0010;
    localparam logic [15:0] OFF_RX_COUNT = 16'h0014;
    localparam logic [15:0] OFF_SCRATCH  = 16'h0018;

    localparam int CTRL_TX_EN    = 0;
    localparam int CTRL_RX_EN    = 1;
    localparam int CTRL_RX_CHAN  = 2;
    localparam int CTRL_DAC_DUAL = 3;

    localparam int STAT_RX_OVF = 0;
    localparam int STAT_TX_UNF = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [31:0] CORE_ID_DEFAULT = 32'h5750_4859;

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] i;
    } iq_t;

    function automatic logic reg_mapped(input logic [15:0] a);
        return (a == OFF_ID) || (a == OFF_CONTROL) || (a == OFF_STATUS) || (a == OFF_IRQ_EN) ||
               (a == OFF_TX_COUNT) || (a == OFF_RX_COUNT) || (a == OFF_SCRATCH);
    endfunction

    function automatic logic [31:0] apply_strb(input logic [31:0] old_v, input logic [31:0] new_v,
                                               input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction
endpackage

// File: rtl/wiphy_fifo.sv
// Single-clock RX sample FIFO; a pop on a full FIFO frees the slot for a same-cycle push.
module wiphy_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;
    logic         wr_en, rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk)
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
endmodule

// File: rtl/wiphy.sv
// Wireless PHY glue: AXI4-Lite register file, AXIS TX to DAC channel 0/1, ADC to AXIS RX via FIFO.
module wiphy
    import wiphy_pkg::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] CORE_ID    = CORE_ID_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_axi_awvalid,
    input  logic [15:0] s_axi_awaddr,
    input  logic [2:0]  s_axi_awprot,
    output logic        s_axi_awready,
    input  logic        s_axi_wvalid,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    output logic        s_axi_wready,
    output logic        s_axi_bvalid,
    output logic [1:0]  s_axi_bresp,
    input  logic        s_axi_bready,
    input  logic        s_axi_arvalid,
    input  logic [15:0] s_axi_araddr,
    input  logic [2:0]  s_axi_arprot,
    output logic        s_axi_arready,
    output logic        s_axi_rvalid,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    input  logic        s_axi_rready,
    input  logic        s_axis_tvalid,
    input  logic [31:0] s_axis_tdata,
    output logic        s_axis_tready,
    output logic        m_axis_tvalid,
    output logic [31:0] m_axis_tdata,
    input  logic        m_axis_tready,
    input  logic        dac_valid_i0, dac_valid_q0, dac_valid_i1, dac_valid_q1,
    output logic [15:0] dac_data_i0, dac_data_q0, dac_data_i1, dac_data_q1,
    input  logic        adc_valid_i0, adc_valid_q0, adc_valid_i1, adc_valid_q1,
    input  logic [15:0] adc_data_i0, adc_data_q0, adc_data_i1, adc_data_q1,
    output logic        irq
);
    logic [3:0]  control;
    logic [1:0]  status, irq_en, status_clr;
    logic [31:0] scratch, tx_count, rx_count, rd_data_c;
    logic [1:0]  rd_resp_c;
    logic        wr_fire, rd_fire, tx_en, rx_en, tx_req, tx_unf_set, rx_ovf_set;
    logic        rx_push, rx_pop, rx_full, rx_empty, rx_accept;
    iq_t         tx_iq, rx_iq;
    logic        unused_ok;

    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, dac_valid_q0, dac_valid_i1, dac_valid_q1,
                         adc_valid_q0, adc_valid_q1};

    assign tx_en   = control[CTRL_TX_EN];
    assign rx_en   = control[CTRL_RX_EN];
    assign wr_fire = s_axi_awready & s_axi_awvalid & s_axi_wvalid;
    assign rd_fire = s_axi_arready & s_axi_arvalid;

    // AXI-Lite handshakes: ready pulses one cycle, response follows on the next edge
    always_ff @(posedge clk) begin
        if (reset) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= RESP_OKAY;
        end else begin
            s_axi_awready <= ~s_axi_awready & s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid;
            s_axi_wready  <= ~s_axi_awready & s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid;
            s_axi_arready <= ~s_axi_arready & s_axi_arvalid & ~s_axi_rvalid;
            if (wr_fire) begin
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= reg_mapped(s_axi_awaddr) ? RESP_OKAY : RESP_SLVERR;
            end else if (s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end
            if (rd_fire) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= rd_data_c;
                s_axi_rresp  <= rd_resp_c;
            end else if (s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_data_c = '0;
        rd_resp_c = RESP_OKAY;
        case (s_axi_araddr)
            OFF_ID:       rd_data_c = CORE_ID;
            OFF_CONTROL:  rd_data_c = {28'd0, control};
            OFF_STATUS:   rd_data_c = {30'd0, status};
            OFF_IRQ_EN:   rd_data_c = {30'd0, irq_en};
            OFF_TX_COUNT: rd_data_c = tx_count;
            OFF_RX_COUNT: rd_data_c = rx_count;
            OFF_SCRATCH:  rd_data_c = scratch;
            default:      rd_resp_c = RESP_SLVERR;
        endcase
    end

    always_comb begin
        status_clr = 2'b00;
        if (wr_fire && s_axi_awaddr == OFF_STATUS && s_axi_wstrb[0])
            status_clr = s_axi_wdata[1:0];
    end

    assign tx_req     = tx_en & dac_valid_i0;
    assign tx_unf_set = tx_req & ~s_axis_tvalid;
    assign tx_iq      = s_axis_tdata;
    assign rx_iq      = control[CTRL_RX_CHAN] ? {adc_data_q1, adc_data_i1} : {adc_data_q0, adc_data_i0};
    assign rx_push    = rx_en & (control[CTRL_RX_CHAN] ? adc_valid_i1 : adc_valid_i0);
    assign rx_pop     = m_axis_tvalid & m_axis_tready;
    assign rx_accept  = rx_push & (~rx_full | rx_pop);
    assign rx_ovf_set = rx_push & ~rx_accept;

    // Set events take priority over a same-cycle W1C clear
    always_ff @(posedge clk) begin
        if (reset) begin
            control  <= '0;
            status   <= '0;
            irq_en   <= '0;
            scratch  <= '0;
            tx_count <= '0;
            rx_count <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr_fire) begin
                case (s_axi_awaddr)
                    OFF_CONTROL: if (s_axi_wstrb[0]) control <= s_axi_wdata[3:0];
                    OFF_IRQ_EN:  if (s_axi_wstrb[0]) irq_en  <= s_axi_wdata[1:0];
                    OFF_SCRATCH: scratch <= apply_strb(scratch, s_axi_wdata, s_axi_wstrb);
                    default: ;
                endcase
            end
            status <= (status & ~status_clr) | {tx_unf_set, rx_ovf_set};
            irq    <= |(status & irq_en);
            if (tx_req && s_axis_tvalid) tx_count <= tx_count + 32'd1;
            if (rx_accept) rx_count <= rx_count + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !tx_en) begin
            dac_data_i0 <= '0;
            dac_data_q0 <= '0;
        end else if (tx_req) begin
            dac_data_i0 <= s_axis_tvalid ? tx_iq.i : 16'd0;
            dac_data_q0 <= s_axis_tvalid ? tx_iq.q : 16'd0;
        end
    end

    assign s_axis_tready = tx_req;
    assign dac_data_i1   = control[CTRL_DAC_DUAL] ? dac_data_i0 : 16'd0;
    assign dac_data_q1   = control[CTRL_DAC_DUAL] ? dac_data_q0 : 16'd0;
    assign m_axis_tvalid = ~rx_empty;

    wiphy_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .wdata (rx_iq),
        .pop   (rx_pop),
        .rdata (m_axis_tdata),
        .full  (rx_full),
        .empty (rx_empty)
    );
endmodule

// File: tb/tb_wiphy.sv
// Directed bench for wiphy: expected AXI/AXIS responses are queued and checked by negedge monitors.
module tb_wiphy;
    logic        clk = 0, reset = 1;
    logic        s_axi_awvalid = 0, s_axi_wvalid = 0, s_axi_bready = 1;
    logic [15:0] s_axi_awaddr = 0, s_axi_araddr = 0;
    logic [2:0]  s_axi_awprot = 0, s_axi_arprot = 0;
    logic [31:0] s_axi_wdata = 0;
    logic [3:0]  s_axi_wstrb = 0;
    logic        s_axi_arvalid = 0, s_axi_rready = 1;
    logic        s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
    logic [1:0]  s_axi_bresp, s_axi_rresp;
    logic [31:0] s_axi_rdata;
    logic        s_axis_tvalid = 0, s_axis_tready;
    logic [31:0] s_axis_tdata = 0;
    logic        m_axis_tvalid, m_axis_tready = 0;
    logic [31:0] m_axis_tdata;
    logic        dac_valid_i0 = 0, dac_valid_q0 = 0, dac_valid_i1 = 0, dac_valid_q1 = 0;
    logic [15:0] dac_data_i0, dac_data_q0, dac_data_i1, dac_data_q1;
    logic        adc_valid_i0 = 0, adc_valid_q0 = 0, adc_valid_i1 = 0, adc_valid_q1 = 0;
    logic [15:0] adc_data_i0 = 0, adc_data_q0 = 0, adc_data_i1 = 0, adc_data_q1 = 0;
    logic        irq;

    int nvec = 0, nerr = 0;
    logic [1:0]  wr_q[$];
    logic [33:0] rd_q[$];
    logic [31:0] rx_q[$];
    logic [1:0]  exp_b;
    logic [33:0] exp_r;
    logic [31:0] exp_s;

    wiphy dut (
        .clk(clk), .reset(reset),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awready(s_axi_awready), .s_axi_wvalid(s_axi_wvalid), .s_axi_wdata(s_axi_wdata),
        .s_axi_wstrb(s_axi_wstrb), .s_axi_wready(s_axi_wready), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bresp(s_axi_bresp), .s_axi_bready(s_axi_bready), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot), .s_axi_arready(s_axi_arready),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rready(s_axi_rready), .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
        .s_axis_tready(s_axis_tready), .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
        .m_axis_tready(m_axis_tready),
        .dac_valid_i0(dac_valid_i0), .dac_valid_q0(dac_valid_q0), .dac_valid_i1(dac_valid_i1),
        .dac_valid_q1(dac_valid_q1), .dac_data_i0(dac_data_i0), .dac_data_q0(dac_data_q0),
        .dac_data_i1(dac_data_i1), .dac_data_q1(dac_data_q1),
        .adc_valid_i0(adc_valid_i0), .adc_valid_q0(adc_valid_q0), .adc_valid_i1(adc_valid_i1),
        .adc_valid_q1(adc_valid_q1), .adc_data_i0(adc_data_i0), .adc_data_q0(adc_data_q0),
        .adc_data_i1(adc_data_i1), .adc_data_q1(adc_data_q1), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Response monitors
    always @(negedge clk) begin
        if (!reset && s_axi_bvalid && s_axi_bready) begin
            nvec++;
            if (wr_q.size() == 0) begin
                nerr++; $display("FAIL bresp_unexpected got=%h", s_axi_bresp);
            end else begin
                exp_b = wr_q.pop_front();
                if (s_axi_bresp !== exp_b) begin
                    nerr++; $display("FAIL bresp got=%h exp=%h", s_axi_bresp, exp_b);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && s_axi_rvalid && s_axi_rready) begin
            nvec++;
            if (rd_q.size() == 0) begin
                nerr++; $display("FAIL rdata_unexpected got=%h", s_axi_rdata);
            end else begin
                exp_r = rd_q.pop_front();
                if ({s_axi_rresp, s_axi_rdata} !== exp_r) begin
                    nerr++;
                    $display("FAIL rdata got=%h/%h exp=%h/%h", s_axi_rresp, s_axi_rdata, exp_r[33:32], exp_r[31:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && m_axis_tvalid && m_axis_tready) begin
            nvec++;
            if (rx_q.size() == 0) begin
                nerr++; $display("FAIL rx_unexpected got=%h", m_axis_tdata);
            end else begin
                exp_s = rx_q.pop_front();
                if (m_axis_tdata !== exp_s) begin
                    nerr++; $display("FAIL rx_sample got=%h exp=%h", m_axis_tdata, exp_s);
                end
            end
        end
    end

    task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] er);
        int n = 0;
        wr_q.push_back(er);
        @(posedge clk); #1;
        s_axi_awvalid = 1; s_axi_wvalid = 1; s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
        do begin @(negedge clk); n++; end while (!s_axi_awready && n < 20);
        if (!s_axi_awready) begin nvec++; nerr++; $display("FAIL awready_timeout addr=%h", a); end
        @(posedge clk); #1;
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic axi_read(input logic [15:0] a, input logic [31:0] ed, input logic [1:0] er);
        int n = 0;
        rd_q.push_back({er, ed});
        @(posedge clk); #1;
        s_axi_arvalid = 1; s_axi_araddr = a;
        do begin @(negedge clk); n++; end while (!s_axi_arready && n < 20);
        if (!s_axi_arready) begin nvec++; nerr++; $display("FAIL arready_timeout addr=%h", a); end
        @(posedge clk); #1;
        s_axi_arvalid = 0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("rst_dac_i0", {16'd0, dac_data_i0}, 0);
        check("rst_dac_q1", {16'd0, dac_data_q1}, 0);
        check("rst_irq", {31'd0, irq}, 0);
        check("rst_valids", {28'd0, s_axi_bvalid, s_axi_rvalid, m_axis_tvalid, s_axis_tready}, 0);

        axi_read(16'h0000, 32'h5750_4859, 2'b00);
        axi_read(16'h0040, 32'h0, 2'b10);
        axi_write(16'h0040, 32'hFFFF_FFFF, 4'hF, 2'b10);
        axi_write(16'h0000, 32'h1111_1111, 4'hF, 2'b00);
        axi_read(16'h0000, 32'h5750_4859, 2'b00);
        axi_write(16'h0018, 32'hA5A5_A5A5, 4'b0011, 2'b00);
        axi_read(16'h0018, 32'h0000_A5A5, 2'b00);
        axi_write(16'h0018, 32'h1234_5678, 4'b1100, 2'b00);
        axi_read(16'h0018, 32'h1234_A5A5, 2'b00);

        // TX: tx_en + dac_dual
        axi_write(16'h0004, 32'hFFFF_FF09, 4'hF, 2'b00);
        axi_read(16'h0004, 32'h9, 2'b00);
        @(posedge clk); #1;
        s_axis_tdata = 32'h1234_5678; s_axis_tvalid = 1; dac_valid_i0 = 1;
        @(negedge clk);
        check("tx_tready", {31'd0, s_axis_tready}, 1);
        @(posedge clk); #1;
        s_axis_tvalid = 0; dac_valid_i0 = 0;
        check("tx_dac_i0", {16'd0, dac_data_i0}, 32'h5678);
        check("tx_dac_q0", {16'd0, dac_data_q0}, 32'h1234);
        check("tx_dac_i1", {16'd0, dac_data_i1}, 32'h5678);
        check("tx_dac_q1", {16'd0, dac_data_q1}, 32'h1234);
        repeat (2) @(posedge clk); #1;
        check("tx_hold_i0", {16'd0, dac_data_i0}, 32'h5678);
        axi_read(16'h0010, 32'd1, 2'b00);
        axi_read(16'h0008, 32'd0, 2'b00);
        axi_write(16'h0004, 32'h1, 4'h1, 2'b00);
        check("single_i1", {dac_data_q1, dac_data_i1}, 0);
        check("single_i0_hold", {16'd0, dac_data_i0}, 32'h5678);

        // Underflow and irq
        axi_write(16'h000C, 32'h2, 4'h1, 2'b00);
        @(posedge clk); #1;
        dac_valid_i0 = 1;
        @(posedge clk); #1;
        dac_valid_i0 = 0;
        check("unf_dac_i0", {16'd0, dac_data_i0}, 0);
        check("unf_irq_lag", {31'd0, irq}, 0);
        @(posedge clk); #1;
        check("unf_irq", {31'd0, irq}, 1);
        axi_read(16'h0008, 32'd2, 2'b00);
        axi_write(16'h0008, 32'h2, 4'h1, 2'b00);
        check("irq_cleared", {31'd0, irq}, 0);
        axi_read(16'h0008, 32'd0, 2'b00);
        axi_write(16'h0004, 32'h0, 4'h1, 2'b00);
        check("txoff_dac", {dac_data_q0, dac_data_i0}, 0);
        axi_read(16'h0010, 32'd1, 2'b00);

        // RX overflow on channel 1, channel 0 carries distractor data
        axi_write(16'h0004, 32'h6, 4'h1, 2'b00);
        adc_valid_i0 = 1; adc_data_i0 = 16'hDEAD; adc_data_q0 = 16'hBEEF;
        check("rx_empty", {31'd0, m_axis_tvalid}, 0);
        for (int k = 0; k < 17; k++) begin
            @(posedge clk); #1;
            if (k == 1) check("rx_latency", {31'd0, m_axis_tvalid}, 1);
            adc_valid_i1 = 1; adc_data_i1 = 16'h1000 + 16'(k); adc_data_q1 = 16'hA000 + 16'(k);
            if (k < 16) rx_q.push_back({16'hA000 + 16'(k), 16'h1000 + 16'(k)});
        end
        @(posedge clk); #1;
        adc_valid_i1 = 0;
        axi_read(16'h0008, 32'd1, 2'b00);
        axi_read(16'h0014, 32'd16, 2'b00);
        @(posedge clk); #1;
        m_axis_tready = 1;
        repeat (20) @(posedge clk); #1;
        m_axis_tready = 0;
        check("rx_drained", {31'd0, m_axis_tvalid}, 0);
        check("rx_q_empty1", rx_q.size(), 0);

        // Full FIFO with simultaneous push and pop: no overflow
        axi_write(16'h0008, 32'h1, 4'h1, 2'b00);
        for (int k = 0; k < 17; k++) begin
            @(posedge clk); #1;
            if (k == 16) m_axis_tready = 1;
            adc_valid_i1 = 1; adc_data_i1 = 16'h2000 + 16'(k); adc_data_q1 = 16'hB000 + 16'(k);
            rx_q.push_back({16'hB000 + 16'(k), 16'h2000 + 16'(k)});
        end
        @(posedge clk); #1;
        adc_valid_i1 = 0;
        repeat (20) @(posedge clk); #1;
        m_axis_tready = 0;
        axi_read(16'h0008, 32'd0, 2'b00);
        axi_read(16'h0014, 32'd33, 2'b00);

        repeat (3) @(negedge clk);
        check("wr_q_empty", wr_q.size(), 0);
        check("rd_q_empty", rd_q.size(), 0);
        check("rx_q_empty2", rx_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
